// File: rtl/elevator_scheduler.sv
// Four-floor elevator scheduler: IDLE/MOVE/DOOR controller with latched floor calls.
// Optional macro ESTOP_EN adds an emergency-stop input that freezes travel and holds the door open.
module elevator_scheduler #(
  parameter logic [6:0] TRAVEL_TICKS = 7'd8
) (
  input  logic       CP,
  input  logic       RST,
  input  logic [3:0] req_in,
  input  logic       endOpen,
`ifdef ESTOP_EN
  input  logic       estop,
`endif
  output logic       StOpen,
  output logic [1:0] floor,
  output logic       dir_up,
  output logic       moving,
  output logic [3:0] req_pending
);

  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    DOOR = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       floor_n;
  logic             dir_n;
  logic [3:0]       pend_n, calls, set_v, clr_v;
  logic             halt;

`ifdef ESTOP_EN
  assign halt = estop;
`else
  assign halt = 1'b0;
`endif

  function automatic logic [3:0] above_mask(input logic [1:0] f);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (2'(i) > f);
    return m;
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] f);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (2'(i) < f);
    return m;
  endfunction

  // Next-state, travel and call-latch logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    floor_n = floor;
    dir_n   = dir_up;
    set_v   = req_in;
    clr_v   = '0;
    calls   = req_pending | req_in;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (req_pending[floor]) begin
          state_n = DOOR;
        end else if (!halt) begin
          if (dir_up && |(req_pending & above_mask(floor))) begin
            state_n = MOVE;
          end else if (|(req_pending & below_mask(floor))) begin
            state_n = MOVE;
            dir_n   = 1'b0;
          end else if (|(req_pending & above_mask(floor))) begin
            state_n = MOVE;
            dir_n   = 1'b1;
          end
        end
      end
      MOVE: begin
        if (!halt) begin
          if (cnt == TRAVEL_TICKS - 7'd1) begin
            cnt_n = '0;
            // Saturating step keeps the floor in range even if a call vanished mid-travel
            if (dir_up && floor != 2'd3)       floor_n = floor + 2'd1;
            else if (!dir_up && floor != 2'd0) floor_n = floor - 2'd1;
            if (calls[floor_n])
              state_n = DOOR;
            else if (dir_up ? |(calls & above_mask(floor_n)) : |(calls & below_mask(floor_n)))
              state_n = MOVE;
            else
              state_n = IDLE;
          end else begin
            cnt_n = cnt + 7'd1;
          end
        end
      end
      DOOR: begin
        if (endOpen && !halt) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Calls for the floor with the door open are dropped; arrival clears the served floor
    if (state == DOOR) set_v[floor] = 1'b0;
    if (state_n == DOOR && state != DOOR) clr_v[floor_n] = 1'b1;
    pend_n = (req_pending | set_v) & ~clr_v;
  end

  always_ff @(posedge CP) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      floor       <= 2'd0;
      dir_up      <= 1'b1;
      moving      <= 1'b0;
      StOpen      <= 1'b0;
      req_pending <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      floor       <= floor_n;
      dir_up      <= dir_n;
      moving      <= (state_n == MOVE) && !halt;
      StOpen      <= (state_n == DOOR);
      req_pending <= pend_n;
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler (TRAVEL_TICKS=8); build with ESTOP_EN to cover the stop input.
module tb_elevator_scheduler;

  typedef struct packed {
    logic       st;
    logic [1:0] fl;
    logic       up;
    logic       mv;
    logic [3:0] pend;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       eo;
    exp_t       e;
  } vec_t;

  logic       CP;
  logic       RST;
  logic [3:0] req_in;
  logic       endOpen;
  logic       StOpen;
  logic [1:0] floor;
  logic       dir_up;
  logic       moving;
  logic [3:0] req_pending;
`ifdef ESTOP_EN
  logic       estop;
`endif

  int total = 0;
  int bad   = 0;
  exp_t  sb_q[$];
  string nm_q[$];
  vec_t  tbl[8];

  elevator_scheduler #(.TRAVEL_TICKS(7'd8)) dut (
    .CP(CP),
    .RST(RST),
    .req_in(req_in),
    .endOpen(endOpen),
`ifdef ESTOP_EN
    .estop(estop),
`endif
    .StOpen(StOpen),
    .floor(floor),
    .dir_up(dir_up),
    .moving(moving),
    .req_pending(req_pending)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  function automatic exp_t mk(input logic st, input logic [1:0] fl, input logic up,
                              input logic mv, input logic [3:0] pend);
    exp_t e;
    e.st = st; e.fl = fl; e.up = up; e.mv = mv; e.pend = pend;
    return e;
  endfunction

  // One clock with a scoreboarded expectation for the outputs after the edge
  task automatic cyc(input logic r, input logic [3:0] rq, input logic eo,
                     input exp_t e, input string name);
    exp_t  want;
    exp_t  got;
    string n;
    sb_q.push_back(e);
    nm_q.push_back(name);
    RST = r; req_in = rq; endOpen = eo;
    @(posedge CP);
    #1;
    want = sb_q.pop_front();
    n    = nm_q.pop_front();
    got  = {StOpen, floor, dir_up, moving, req_pending};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got st=%b fl=%0d up=%b mv=%b pend=%b, want st=%b fl=%0d up=%b mv=%b pend=%b",
               n, got.st, got.fl, got.up, got.mv, got.pend,
               want.st, want.fl, want.up, want.mv, want.pend);
    end
  endtask

  task automatic run(input int n);
    RST = 1'b0; req_in = 4'b0000; endOpen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge CP);
      #1;
    end
  endtask

  task automatic do_reset();
    cyc(1'b1, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0000), "reset");
  endtask

  initial begin
    RST = 1'b1; req_in = 4'b0000; endOpen = 1'b0;
`ifdef ESTOP_EN
    estop = 1'b0;
`endif

    // Reset, floor-0 call and door cycle, endOpen ignored outside DOOR
    tbl[0] = '{1'b1, 4'b1111, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0000)};
    tbl[1] = '{1'b0, 4'b0001, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0001)};
    tbl[2] = '{1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd0, 1'b1, 1'b0, 4'b0000)};
    tbl[3] = '{1'b0, 4'b0001, 1'b0, mk(1'b1, 2'd0, 1'b1, 1'b0, 4'b0000)};
    tbl[4] = '{1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0000)};
    tbl[5] = '{1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0000)};
    tbl[6] = '{1'b0, 4'b0010, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0010)};
    tbl[7] = '{1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0010)};
    for (int i = 0; i < 8; i++)
      cyc(tbl[i].rst, tbl[i].req, tbl[i].eo, tbl[i].e, $sformatf("vec%0d", i));

    // Express run 0 -> 3: one floor every 8 edges, door opens on arrival
    do_reset();
    cyc(1'b0, 4'b1000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b1000), "up_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b1000), "up_depart");
    run(6);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b1000), "up_edge7");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd1, 1'b1, 1'b1, 4'b1000), "up_fl1");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd2, 1'b1, 1'b1, 4'b1000), "up_fl2");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd3, 1'b1, 1'b0, 4'b0000), "up_fl3_door");
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd3, 1'b1, 1'b0, 4'b0000), "up_close");

    // Intermediate call picked up en route, then resume upward
    do_reset();
    cyc(1'b0, 4'b1000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b1000), "mid_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b1000), "mid_depart");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd1, 1'b1, 1'b1, 4'b1000), "mid_fl1");
    cyc(1'b0, 4'b0100, 1'b0, mk(1'b0, 2'd1, 1'b1, 1'b1, 4'b1100), "mid_call2");
    run(6);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd2, 1'b1, 1'b0, 4'b1000), "mid_stop2");
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd2, 1'b1, 1'b0, 4'b1000), "mid_close");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd2, 1'b1, 1'b1, 4'b1000), "mid_resume");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd3, 1'b1, 1'b0, 4'b0000), "mid_fl3");

    // Call arriving on the terminal edge stops there; clear beats set
    do_reset();
    cyc(1'b0, 4'b1000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b1000), "late_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b1000), "late_depart");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd1, 1'b1, 1'b1, 4'b1000), "late_fl1");
    run(7);
    cyc(1'b0, 4'b0100, 1'b0, mk(1'b1, 2'd2, 1'b1, 1'b0, 4'b1000), "late_stop2");

    // From floor 1 going up with calls at 3 and 0: serve 3, then reverse to 0
    do_reset();
    cyc(1'b0, 4'b0010, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0010), "rev_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0010), "rev_depart");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd1, 1'b1, 1'b0, 4'b0000), "rev_fl1");
    cyc(1'b0, 4'b1001, 1'b0, mk(1'b1, 2'd1, 1'b1, 1'b0, 4'b1001), "rev_calls");
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd1, 1'b1, 1'b0, 4'b1001), "rev_close1");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd1, 1'b1, 1'b1, 4'b1001), "rev_go_up");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd2, 1'b1, 1'b1, 4'b1001), "rev_fl2");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd3, 1'b1, 1'b0, 4'b0001), "rev_fl3");
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd3, 1'b1, 1'b0, 4'b0001), "rev_close3");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd3, 1'b0, 1'b1, 4'b0001), "rev_go_down");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd2, 1'b0, 1'b1, 4'b0001), "rev_dn2");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd1, 1'b0, 1'b1, 4'b0001), "rev_dn1");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd0, 1'b0, 1'b0, 4'b0000), "rev_fl0");

    // Door at floor 2 drops its own call; reset mid-move aborts everything
    do_reset();
    cyc(1'b0, 4'b0100, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0100), "drop_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0100), "drop_depart");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd1, 1'b1, 1'b1, 4'b0100), "drop_fl1");
    run(7);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd2, 1'b1, 1'b0, 4'b0000), "drop_door2");
    cyc(1'b0, 4'b0100, 1'b0, mk(1'b1, 2'd2, 1'b1, 1'b0, 4'b0000), "drop_own");
    cyc(1'b0, 4'b0101, 1'b0, mk(1'b1, 2'd2, 1'b1, 1'b0, 4'b0001), "drop_other");
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd2, 1'b1, 1'b0, 4'b0001), "drop_close");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd2, 1'b0, 1'b1, 4'b0001), "drop_go_down");
    run(3);
    cyc(1'b1, 4'b1111, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0000), "rst_mid_move");
    cyc(1'b0, 4'b0010, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0010), "post_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0010), "post_depart");
    run(6);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0010), "post_edge7");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd1, 1'b1, 1'b0, 4'b0000), "post_fl1");

`ifdef ESTOP_EN
    // Emergency stop for 20 edges mid-travel delays arrival by exactly 20 edges
    do_reset();
    cyc(1'b0, 4'b0010, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0010), "es_latch");
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0010), "es_depart");
    run(3);
    estop = 1'b1;
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0010), "es_halt");
    run(18);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b0, 4'b0010), "es_frozen");
    estop = 1'b0;
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b0, 2'd0, 1'b1, 1'b1, 4'b0010), "es_release");
    run(3);
    cyc(1'b0, 4'b0000, 1'b0, mk(1'b1, 2'd1, 1'b1, 1'b0, 4'b0000), "es_arrive");
    estop = 1'b1;
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b1, 2'd1, 1'b1, 1'b0, 4'b0000), "es_door_hold");
    estop = 1'b0;
    cyc(1'b0, 4'b0000, 1'b1, mk(1'b0, 2'd1, 1'b1, 1'b0, 4'b0000), "es_door_close");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
